// File: rtl/rf_seq_pkg.sv
// Purpose : shared opcode and FSM state definitions for regfile_op_sequencer.
// Contents: OP_WRITE_IMM..OP_CLEAR_ALL opcode constants, state_t FSM encoding.
package rf_seq_pkg;

  localparam logic [1:0] OP_WRITE_IMM = 2'b00;
  localparam logic [1:0] OP_COPY      = 2'b01;
  localparam logic [1:0] OP_SWAP      = 2'b10;
  localparam logic [1:0] OP_CLEAR_ALL = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    MV   = 3'd2,
    WR   = 3'd3,
    CLR  = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/regfile.sv
// Purpose : NREG x DW register file, one synchronous write port, one
//           combinational read port.
// Ports   : clk; data_in/writenum/write (write port, commits on posedge clk);
//           readnum -> data_out (combinational read).
module regfile #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic [DW-1:0] data_in,
  input  logic [AW-1:0] writenum,
  input  logic          write,
  input  logic [AW-1:0] readnum,
  output logic [DW-1:0] data_out
);

  localparam int unsigned NREG = 2**AW;

  logic [DW-1:0] r_regs [NREG];

  always_ff @(posedge clk) begin
    if (write) r_regs[writenum] <= data_in;
  end

  assign data_out = r_regs[readnum];

endmodule

// File: rtl/regfile_op_sequencer.sv
// Purpose : command-driven controller sequencing a regfile through its single
//           write port and combinational read port. Commands: WRITE_IMM, COPY,
//           SWAP, CLEAR_ALL; one at a time, done pulse on completion.
// Ports   : clk, reset (sync, active-high);
//           cmd_valid/cmd_ready handshake with cmd_op, cmd_rd, cmd_rs, cmd_imm;
//           done/err completion pulses;
//           rf_readnum, rf_writenum, rf_write, rf_data_in -> regfile,
//           rf_data_out <- regfile (combinational in rf_readnum).
// Config  : RF_SEQ_SWAP_EN defined builds the SWAP sequence (MV state);
//           undefined, SWAP is rejected with done+err and no writes.
module regfile_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs,
  input  logic [DW-1:0] cmd_imm,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] rf_readnum,
  output logic [AW-1:0] rf_writenum,
  output logic          rf_write,
  output logic [DW-1:0] rf_data_in,
  input  logic [DW-1:0] rf_data_out
);

  localparam int unsigned NREG = 2**AW;
`ifdef RF_SEQ_SWAP_EN
  localparam bit SWAP_BUILT = 1'b1;
`else
  localparam bit SWAP_BUILT = 1'b0;
`endif

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_op;
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_rs;
  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_tmp;
  logic          r_err;
  logic          w_hs;

  assign cmd_ready = (r_state == IDLE) && !reset;
  assign w_hs      = cmd_valid && cmd_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_hs) begin
          case (cmd_op)
            OP_WRITE_IMM: w_next = WR;
            OP_COPY:      w_next = RD;
            OP_SWAP:      w_next = SWAP_BUILT ? RD : DONE;
            default:      w_next = CLR;
          endcase
        end
      end
      RD:      w_next = (SWAP_BUILT && (r_op == OP_SWAP)) ? MV : WR;
`ifdef RF_SEQ_SWAP_EN
      MV:      w_next = WR;
`endif
      WR:      w_next = DONE;
      CLR:     w_next = (r_cnt == AW'(NREG - 1)) ? DONE : CLR;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // tmp holds the immediate from handshake; COPY/SWAP overwrite it in RD, so
  // WR always writes r_tmp regardless of opcode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_rd    <= '0;
      r_rs    <= '0;
      r_tmp   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_op  <= cmd_op;
        r_rd  <= cmd_rd;
        r_rs  <= cmd_rs;
        r_tmp <= cmd_imm;
        r_err <= !SWAP_BUILT && (cmd_op == OP_SWAP);
      end
      if (r_state == RD) r_tmp <= rf_data_out;
      // Natural wrap brings cnt back to 0 after the last CLR cycle.
      if (r_state == CLR) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    rf_readnum  = '0;
    rf_writenum = '0;
    rf_write    = 1'b0;
    rf_data_in  = '0;
    done        = 1'b0;
    err         = 1'b0;
    if (!reset) begin
      case (r_state)
        RD: rf_readnum = r_rs;
`ifdef RF_SEQ_SWAP_EN
        MV: begin
          rf_readnum  = r_rd;
          rf_writenum = r_rs;
          rf_data_in  = rf_data_out;
          rf_write    = 1'b1;
        end
`endif
        WR: begin
          rf_writenum = r_rd;
          rf_data_in  = r_tmp;
          rf_write    = 1'b1;
        end
        CLR: begin
          rf_writenum = r_cnt;
          rf_write    = 1'b1;
        end
        DONE: begin
          done = 1'b1;
          err  = r_err;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench for regfile_op_sequencer driving a regfile instance.
module tb_regfile_op_sequencer;
  import rf_seq_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;
`ifdef RF_SEQ_SWAP_EN
  localparam bit SWAP_ON = 1'b1;
`else
  localparam bit SWAP_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_rd;
  logic [AW-1:0] cmd_rs;
  logic [DW-1:0] cmd_imm;
  logic          done;
  logic          err;
  logic [AW-1:0] rf_readnum;
  logic [AW-1:0] rf_writenum;
  logic          rf_write;
  logic [DW-1:0] rf_data_in;
  logic [DW-1:0] rf_data_out;

  always #5 clk = ~clk;

  regfile #(.DW(DW), .AW(AW)) u_rf (
    .clk      (clk),
    .data_in  (rf_data_in),
    .writenum (rf_writenum),
    .write    (rf_write),
    .readnum  (rf_readnum),
    .data_out (rf_data_out)
  );

  regfile_op_sequencer #(.DW(DW), .AW(AW)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_rd      (cmd_rd),
    .cmd_rs      (cmd_rs),
    .cmd_imm     (cmd_imm),
    .done        (done),
    .err         (err),
    .rf_readnum  (rf_readnum),
    .rf_writenum (rf_writenum),
    .rf_write    (rf_write),
    .rf_data_in  (rf_data_in),
    .rf_data_out (rf_data_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Log of every write cycle's address, sampled mid-cycle.
  logic [AW-1:0] wr_log[$];
  always @(negedge clk) if (rf_write) wr_log.push_back(rf_writenum);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Issue one command; lat = cycles from handshake edge to done (99 = timeout),
  // smp = rf_data_out in the first cycle after handshake.
  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                         input logic [DW-1:0] imm, output int lat, output logic errv,
                         output logic [DW-1:0] smp);
    int g;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_imm = imm;
    g = 0;
    while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    smp = rf_data_out;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    errv = err;
    if (!done) lat = 99;
  endtask

  task automatic read_reg(input logic [AW-1:0] r, output logic [DW-1:0] v);
    int l; logic e;
    run_cmd(OP_COPY, r, r, '0, l, e, v);
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs;
    logic [DW-1:0] imm;
    int            lat;
    logic          errx;
    int            nwr;
    logic [AW-1:0] chk;
    logic [DW-1:0] val;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat; logic e; logic [DW-1:0] v; int base;
    int hs, first_done, second_hs, rdy_cnt, g;

    vecs[0] = '{OP_WRITE_IMM, 3'd1, 3'd0, 16'h0027, 2, 1'b0, 1, 3'd1, 16'h0027};
    vecs[1] = '{OP_WRITE_IMM, 3'd2, 3'd0, 16'h01E3, 2, 1'b0, 1, 3'd2, 16'h01E3};
    vecs[2] = '{OP_WRITE_IMM, 3'd7, 3'd0, 16'h1000, 2, 1'b0, 1, 3'd7, 16'h1000};
    vecs[3] = '{OP_WRITE_IMM, 3'd3, 3'd0, 16'h912A, 2, 1'b0, 1, 3'd3, 16'h912A};
    vecs[4] = '{OP_COPY,      3'd5, 3'd3, 16'hFFFF, 3, 1'b0, 1, 3'd5, 16'h912A};
    vecs[5] = '{OP_COPY,      3'd6, 3'd1, 16'hFFFF, 3, 1'b0, 1, 3'd6, 16'h0027};
    vecs[6] = '{OP_SWAP, 3'd7, 3'd2, 16'hFFFF, SWAP_ON ? 4 : 1, !SWAP_ON, SWAP_ON ? 2 : 0,
                3'd2, SWAP_ON ? 16'h1000 : 16'h01E3};
    vecs[7] = '{OP_SWAP, 3'd7, 3'd7, 16'hFFFF, SWAP_ON ? 4 : 1, !SWAP_ON, SWAP_ON ? 2 : 0,
                3'd7, SWAP_ON ? 16'h01E3 : 16'h1000};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs = '0; cmd_imm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", cmd_ready, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_write", rf_write, 0);
    check("rst_writenum", rf_writenum, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_done", done, 0);

    for (int i = 0; i < 8; i++) begin
      base = wr_log.size();
      run_cmd(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm, lat, e, v);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_err", i), e, vecs[i].errx);
      check($sformatf("v%0d_nwr", i), wr_log.size() - base, vecs[i].nwr);
      @(negedge clk);
      check($sformatf("v%0d_done_1cyc", i), done, 0);
      check($sformatf("v%0d_ready_after", i), cmd_ready, 1);
      read_reg(vecs[i].chk, v);
      check($sformatf("v%0d_R%0d", i, vecs[i].chk), v, vecs[i].val);
    end
    read_reg(3'd1, v);
    check("R1_unchanged", v, 16'h0027);

    // CLEAR_ALL with all registers nonzero.
    for (int i = 0; i < 8; i++) run_cmd(OP_WRITE_IMM, AW'(i), '0, DW'((i + 1) * 16'h1111), lat, e, v);
    base = wr_log.size();
    run_cmd(OP_CLEAR_ALL, '0, '0, 16'hBEEF, lat, e, v);
    check("clr_lat", lat, 9);
    check("clr_err", e, 0);
    check("clr_nwr", wr_log.size() - base, 8);
    for (int j = 0; j < 8; j++) check($sformatf("clr_addr%0d", j), wr_log[base + j], j);
    for (int i = 0; i < 8; i++) begin
      read_reg(AW'(i), v);
      check($sformatf("clr_R%0d", i), v, 0);
    end

    // Reset in the second CLR cycle: only R0 cleared.
    for (int i = 0; i < 8; i++) run_cmd(OP_WRITE_IMM, AW'(i), '0, DW'((i + 1) * 16'h1111), lat, e, v);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_CLEAR_ALL;
    check("rclr_ready", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("rclr_w0", rf_write, 1);
    check("rclr_wn0", rf_writenum, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("rclr_rst_write", rf_write, 0);
    check("rclr_rst_done", done, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rclr_ready_after", cmd_ready, 1);
    check("rclr_no_done", done, 0);
    for (int i = 0; i < 8; i++) begin
      read_reg(AW'(i), v);
      check($sformatf("rclr_R%0d", i), v, (i == 0) ? 0 : (i + 1) * 16'h1111);
    end

    // cmd_valid held through a SWAP: repeat accepted one cycle after DONE.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_SWAP; cmd_rd = 3'd4; cmd_rs = 3'd2;
    hs = 0; first_done = -1; second_hs = -1; rdy_cnt = 0;
    for (int cyc = 0; cyc < 30 && hs < 2; cyc++) begin
      if (cyc > 0 && cmd_ready) rdy_cnt++;
      if (cmd_ready && cmd_valid) begin
        hs++;
        if (hs == 2) second_hs = cyc;
      end
      if (done && first_done < 0) first_done = cyc;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("held_first_done", first_done, SWAP_ON ? 4 : 1);
    check("held_second_hs", second_hs, SWAP_ON ? 5 : 2);
    check("held_ready_cycles", rdy_cnt, 1);
    g = 0;
    while (!done && g < 20) begin @(negedge clk); g++; end
    check("held_second_done", done, 1);
    read_reg(3'd2, v);
    check("held_R2", v, 16'h3333);
    read_reg(3'd4, v);
    check("held_R4", v, 16'h5555);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
